// File: rtl/canvas_store.sv
// -----------------------------------------------------------------------------
// canvas_store
//
// A 1-bit-per-pixel frame store for a WIDTH x HEIGHT canvas. It has one write
// port, which drawing logic and the internal clear sweep share, and one
// synchronous read port that follows the display scan.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset; a full clear sweep follows it
//   write_addr   linear pixel address x + y*WIDTH (19 bits)
//   write_enable write request for this cycle
//   write_data   pixel value to store (1 = ink, 0 = erase)
//   clear_req    level-sampled request to start a clear sweep from IDLE
//   h_cnt/v_cnt  display scan coordinates (10 bits each)
//   pixel_out    stored pixel for the scan position presented 2 cycles earlier
//   busy         high while a clear sweep runs
//   clear_done   one-cycle pulse after the last clear write
//   drop_cnt     saturating count of rejected write requests
// -----------------------------------------------------------------------------
module canvas_store #(
    parameter int   WIDTH       = 640,
    parameter int   HEIGHT      = 480,
    parameter logic CLEAR_VALUE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] write_addr,
    input  logic        write_enable,
    input  logic        write_data,
    input  logic        clear_req,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    output logic        pixel_out,
    output logic        busy,
    output logic        clear_done,
    output logic [7:0]  drop_cnt
);

    localparam int          DEPTH   = WIDTH * HEIGHT;
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [18:0] TOTAL   = 19'(DEPTH);
    localparam logic [18:0] LAST    = 19'(DEPTH - 1);
    localparam logic [18:0] WIDTH_A = 19'(WIDTH);

    localparam logic IDLE  = 1'b0;
    localparam logic CLEAR = 1'b1;

    logic        state;
    logic        state_next;
    logic [18:0] sweep_cnt;
    logic        sweep_last;
    logic        drop_now;

    logic          mem [0:DEPTH-1];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          mem_wdata;

    logic [18:0]   scan_addr;
    logic          scan_active;
    logic [AW-1:0] read_addr_p1;
    logic          active_p1;
    logic          rd_data_p2;
    logic          active_p2;

    assign sweep_last = (sweep_cnt == LAST);

    // Any request is rejected while the sweep owns the write port.
    assign drop_now = write_enable && ((state == CLEAR) || (write_addr >= TOTAL));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_req)  state_next = CLEAR;
            CLEAR:   if (sweep_last) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            sweep_cnt  <= '0;
            busy       <= 1'b1;
            clear_done <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next == CLEAR);
            clear_done <= (state == CLEAR) && sweep_last;
            if (state == IDLE) begin
                if (clear_req) sweep_cnt <= '0;
            end else begin
                sweep_cnt <= sweep_last ? '0 : sweep_cnt + 19'd1;
            end
            if (drop_now && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Write port arbitration: the sweep takes priority; user writes only in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_addr[AW-1:0];
        mem_wdata = write_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_cnt[AW-1:0];
            mem_wdata = CLEAR_VALUE;
        end else if (write_enable && (write_addr < TOTAL)) begin
            mem_we = 1'b1;
        end
    end

    assign scan_addr   = 19'(v_cnt) * WIDTH_A + 19'(h_cnt);
    assign scan_active = (int'(h_cnt) < WIDTH) && (int'(v_cnt) < HEIGHT);

    // ---- stage p1: scan address and active flag ----
    // ---- stage p2: memory data (read-first against a same-edge write) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_p1 <= 1'b0;
            active_p2 <= 1'b0;
        end else begin
            active_p1 <= scan_active;
            active_p2 <= active_p1;
        end
    end

    // Off-canvas scans fetch address 0 so the index never leaves the array.
    always_ff @(posedge clk) begin
        read_addr_p1 <= scan_active ? scan_addr[AW-1:0] : '0;
        rd_data_p2   <= mem[read_addr_p1];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign pixel_out = active_p2 & rd_data_p2;

endmodule

// File: tb/tb_canvas_store.sv
// -----------------------------------------------------------------------------
// tb_canvas_store
//
// Directed bench for canvas_store on a reduced 40 x 30 canvas (1200 pixels)
// so that every sweep and full-canvas scan stays short.
// -----------------------------------------------------------------------------
module tb_canvas_store;

    localparam int W   = 40;
    localparam int H   = 30;
    localparam int TOT = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] write_addr;
    logic        write_enable;
    logic        write_data;
    logic        clear_req;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        pixel_out;
    logic        busy;
    logic        clear_done;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    canvas_store #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .CLEAR_VALUE(1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_addr  (write_addr),
        .write_enable(write_enable),
        .write_data  (write_data),
        .clear_req   (clear_req),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .pixel_out   (pixel_out),
        .busy        (busy),
        .clear_done  (clear_done),
        .drop_cnt    (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic data);
        write_addr   = 19'(addr);
        write_data   = data;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic read_px(input int x, input int y, output logic px);
        h_cnt = 10'(x);
        v_cnt = 10'(y);
        tick();
        tick();
        px = pixel_out;
    endtask

    task automatic scan_all(output int bad);
        logic px;
        bad = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                read_px(x, y, px);
                if (px !== 1'b0) bad++;
            end
        end
    endtask

    // Ticks until busy drops, with a hard bound so a stuck sweep still ends.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy === 1'b1 && n < 3 * TOT);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic px;
        int   n;
        int   bad;

        rst_n        = 1'b0;
        write_addr   = '0;
        write_enable = 1'b0;
        write_data   = 1'b0;
        clear_req    = 1'b0;
        h_cnt        = '0;
        v_cnt        = '0;
        repeat (3) tick();

        // Reset state
        check("rst_busy", busy, 1);
        check("rst_done", clear_done, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_pixel", pixel_out, 0);
        wr(5, 1'b1);
        check("rst_drop_held", drop_cnt, 0);

        // Power-up sweep
        rst_n = 1'b1;
        wait_done(n);
        check("init_sweep_len", n, TOT);
        check("init_done_pulse", clear_done, 1);
        tick();
        check("init_done_drop", clear_done, 0);
        check("init_busy_low", busy, 0);
        scan_all(bad);
        check("init_blank", bad, 0);

        // Ink at (1,1), exact two-cycle read latency
        wr(41, 1'b1);
        read_px(2, 1, px);
        check("px_2_1", px, 0);
        h_cnt = 10'd1;
        v_cnt = 10'd1;
        tick();
        check("lat_1cyc", pixel_out, 0);
        tick();
        check("lat_2cyc_ink", pixel_out, 1);
        wr(41, 1'b0);
        read_px(1, 1, px);
        check("erase_1_1", px, 0);

        // Off-canvas scans are blank, boundary pixels readable
        wr(0, 1'b1);
        wr(40, 1'b1);
        wr(TOT - 1, 1'b1);
        read_px(700, 10, px);
        check("off_h700", px, 0);
        read_px(5, 500, px);
        check("off_v500", px, 0);
        read_px(W, 0, px);
        check("off_h_edge", px, 0);
        read_px(0, H, px);
        check("off_v_edge", px, 0);
        read_px(W - 1, H - 1, px);
        check("last_px", px, 1);
        read_px(0, 1, px);
        check("px_0_1", px, 1);
        check("drop_before", drop_cnt, 0);
        wr(TOT, 1'b1);
        check("drop_oob", drop_cnt, 1);
        wr(TOT - 1, 1'b0);
        check("drop_inrange", drop_cnt, 1);

        // Clear sweep with writes dropped; clear_req held high is ignored
        clear_req = 1'b1;
        tick();
        check("clr_busy", busy, 1);
        write_enable = 1'b1;
        write_data   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            write_addr = 19'((i * 7) % TOT);
            tick();
        end
        write_enable = 1'b0;
        clear_req    = 1'b0;
        check("clr_drop_sat", drop_cnt, 255);
        check("clr_busy_mid", busy, 1);
        wait_done(n);
        check("clr_len", n, TOT - 300);
        check("clr_done_pulse", clear_done, 1);

        // New sweep starts on the clear_done cycle
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_done_low", clear_done, 0);
        wait_done(n);
        check("restart_len", n, TOT);
        check("restart_done", clear_done, 1);
        scan_all(bad);
        check("clr_blank", bad, 0);

        // Read-first: write addr 100 on the edge that reads it
        h_cnt = 10'd20;
        v_cnt = 10'd2;
        tick();
        wr(100, 1'b1);
        check("rf_old", pixel_out, 0);
        tick();
        check("rf_new", pixel_out, 1);

        // Reset in the middle of a sweep
        wr(1100, 1'b1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (990) tick();
        read_px(20, 27, px);
        check("partial_uncleared", px, 1);
        read_px(20, 2, px);
        check("partial_cleared", px, 0);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1);
        check("abort_drop", drop_cnt, 0);
        check("abort_pixel", pixel_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_busy_hold", busy, 1);
        end
        rst_n = 1'b1;
        wait_done(n);
        check("abort_sweep_len", n, TOT);
        check("abort_done", clear_done, 1);
        scan_all(bad);
        check("abort_blank", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/canvas_store.md
CANVAS_STORE -- requirements
Module: canvas_store

Interface
REQ-001 The block SHALL have parameter WIDTH, default 640, meaning canvas width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 480, meaning canvas height in pixels.
REQ-003 The block SHALL have parameter CLEAR_VALUE, default 1'b0, meaning the pixel value written by a clear sweep (background).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port write_addr, input, 19 bits: linear pixel address, x + y*WIDTH.
REQ-007 The block SHALL have port write_enable, input, 1 bit: write request for this cycle.
REQ-008 The block SHALL have port write_data, input, 1 bit: pixel value to store (1 = ink, 0 = erase).
REQ-009 The block SHALL have port clear_req, input, 1 bit: level-sampled request to start a clear sweep.
REQ-010 The block SHALL have port h_cnt, input, 10 bits: display scan x coordinate.
REQ-011 The block SHALL have port v_cnt, input, 10 bits: display scan y coordinate.
REQ-012 The block SHALL have port pixel_out, output, 1 bit: stored pixel for the scan position presented 2 cycles earlier.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a clear sweep runs.
REQ-014 The block SHALL have port clear_done, output, 1 bit: one-cycle pulse after the last clear write.
REQ-015 The block SHALL have port drop_cnt, output, 8 bits: saturating count of rejected write requests.

Function
REQ-016 Storage SHALL be WIDTH*HEIGHT x 1 bit (307200 bits by default), single write port and single synchronous read port; contents are not reset.
REQ-017 The FSM SHALL have states IDLE and CLEAR.
REQ-018 In IDLE, a write SHALL commit at the clock edge when write_enable=1 and write_addr < WIDTH*HEIGHT.
REQ-019 A write request with write_addr >= WIDTH*HEIGHT, or any write request while in CLEAR, SHALL be dropped and SHALL increment drop_cnt, which saturates at 255.
REQ-020 IDLE -> CLEAR SHALL occur when clear_req=1; the sweep counter loads 0.
REQ-021 In CLEAR, the block SHALL write CLEAR_VALUE to address = sweep counter each cycle and increment the counter by 1.
REQ-022 The cycle that writes address WIDTH*HEIGHT-1 SHALL be the last cycle in CLEAR; the next state is IDLE and clear_done=1 for exactly that following cycle.
REQ-023 clear_req SHALL be ignored while in CLEAR; if it is high on the cycle clear_done pulses, a new sweep starts that cycle.
REQ-024 busy SHALL equal (state == CLEAR) as a registered output.
REQ-025 Read stage 1 SHALL register read_addr = v_cnt*WIDTH + h_cnt and active = (h_cnt < WIDTH && v_cnt < HEIGHT).
REQ-026 Read stage 2 SHALL register memory data; pixel_out SHALL be the stored bit if the stage-2 active flag is set, else 0, for a latency of exactly 2 cycles from h_cnt/v_cnt.
REQ-027 Read and write to the same address in the same cycle SHALL return the old data (read-first).
REQ-028 Reads SHALL continue during CLEAR; pixel_out reflects the partially cleared contents.
REQ-029 Address arithmetic SHALL be 19-bit unsigned; no value wraps within the valid range.

Reset
REQ-030 While rst_n=0: state=CLEAR, sweep counter=0, busy=1, clear_done=0, drop_cnt=0, pixel_out=0, and pipeline active flags=0.
REQ-031 After rst_n deasserts, the block SHALL perform a full clear sweep, so the canvas is known-blank after 307200 cycles.
REQ-032 Asserting rst_n mid-operation SHALL abort any sweep or pending write and restart from the REQ-030 state.

Verification
REQ-033 Release reset, hold inputs idle: busy=1 for exactly 307200 cycles, then clear_done pulses for 1 cycle; reading every address gives 0.
REQ-034 After the sweep, write addr 641 (x=1, y=1) with data=1, then scan h_cnt=1, v_cnt=1: pixel_out=1 exactly 2 cycles later; h_cnt=2, v_cnt=1 gives 0.
REQ-035 Scan h_cnt=700, v_cnt=10, and h_cnt=5, v_cnt=500: pixel_out=0 both times; write addr 307200 with data=1: no write and drop_cnt increments by 1.
REQ-036 Pulse clear_req in IDLE, then issue 300 writes during the sweep: all are dropped, drop_cnt=255 (saturated), and memory is all zero after clear_done.
REQ-037 Write addr 100 with data=1 while scanning addr 100 in the same cycle: the read returns 0; the same read one cycle later returns 1.
REQ-038 Assert rst_n=0 at sweep counter=1000 for 3 cycles: busy stays 1, the counter restarts at 0, and clear_done occurs 307200 cycles after release.
